// File: rtl/fp32_align_shift.sv
// FP32 add/sub pre-alignment: orders operands by magnitude and right-shifts the smaller
// mantissa by the exponent difference (4-bit coarse / 1-bit fine steps) with sticky folding.
module fp32_align_shift (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:0] out_big_m,
    output logic [32:0] out_small_m,
    output logic [7:0]  out_cexp,
    output logic        out_sign,
    output logic        out_eff_sub,
    output logic        out_special
);

    typedef enum logic [1:0] {StIdle, StCmp, StShift, StDone} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        op_q, op_d;
    logic        cmp_phase_q, cmp_phase_d;
    logic [5:0]  rem_q, rem_d;
    logic [32:0] big_m_q, big_m_d;
    logic [32:0] small_m_q, small_m_d;
    logic [7:0]  cexp_q, cexp_d;
    logic        sign_q, sign_d;
    logic        eff_sub_q, eff_sub_d;
    logic        special_q, special_d;

    // Operand unpack from the captured operands
    logic [7:0]  exp_a_raw, exp_b_raw;
    logic [7:0]  exp_a_eff, exp_b_eff;
    logic [32:0] mant_a, mant_b;
    logic        a_big;
    logic [7:0]  exp_diff;
    logic [5:0]  rem_init;

    assign exp_a_raw = a_q[30:23];
    assign exp_b_raw = b_q[30:23];
    assign exp_a_eff = (exp_a_raw == 8'd0) ? 8'd1 : exp_a_raw;
    assign exp_b_eff = (exp_b_raw == 8'd0) ? 8'd1 : exp_b_raw;
    assign mant_a    = {1'b0, exp_a_raw != 8'd0, a_q[22:0], 8'h00};
    assign mant_b    = {1'b0, exp_b_raw != 8'd0, b_q[22:0], 8'h00};
    // Ties go to A, so equal magnitudes keep A's sign
    assign a_big     = (a_q[30:0] >= b_q[30:0]);
    assign exp_diff  = a_big ? (exp_a_eff - exp_b_eff) : (exp_b_eff - exp_a_eff);
    // Beyond 33 every mantissa bit is already in sticky, so clamp
    assign rem_init  = (exp_diff > 8'd33) ? 6'd33 : exp_diff[5:0];

    // Single alignment step
    logic        step_coarse;
    logic [32:0] shift_coarse, shift_fine;
    logic [5:0]  rem_step;

    assign step_coarse  = (rem_q >= 6'd4);
    assign shift_coarse = {4'b0, small_m_q[32:4]} | {32'b0, |small_m_q[3:0]};
    assign shift_fine   = {1'b0, small_m_q[32:1]} | {32'b0, small_m_q[0]};
    assign rem_step     = rem_q - (step_coarse ? 6'd4 : 6'd1);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cmp_phase_d = cmp_phase_q;
        rem_d       = rem_q;
        big_m_d     = big_m_q;
        small_m_d   = small_m_q;
        cexp_d      = cexp_q;
        sign_d      = sign_q;
        eff_sub_d   = eff_sub_q;
        special_d   = special_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d         = in_a;
                    b_d         = in_b;
                    op_d        = in_op;
                    cmp_phase_d = 1'b0;
                    state_d     = StCmp;
                end
            end
            StCmp: begin
                // Phase 0 resolves the magnitude order, phase 1 dispatches on the shift count
                if (!cmp_phase_q) begin
                    big_m_d     = a_big ? mant_a : mant_b;
                    small_m_d   = a_big ? mant_b : mant_a;
                    cexp_d      = a_big ? exp_a_eff : exp_b_eff;
                    sign_d      = a_big ? a_q[31] : (b_q[31] ^ op_q);
                    eff_sub_d   = a_q[31] ^ b_q[31] ^ op_q;
                    special_d   = (exp_a_raw == 8'hFF) || (exp_b_raw == 8'hFF);
                    rem_d       = rem_init;
                    cmp_phase_d = 1'b1;
                end else if (rem_q == 6'd0) begin
                    state_d = StDone;
                end else begin
                    state_d = StShift;
                end
            end
            StShift: begin
                small_m_d = step_coarse ? shift_coarse : shift_fine;
                rem_d     = rem_step;
                if (rem_step == 6'd0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_q        <= 1'b0;
            cmp_phase_q <= 1'b0;
            rem_q       <= 6'd0;
            big_m_q     <= 33'd0;
            small_m_q   <= 33'd0;
            cexp_q      <= 8'd0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            special_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cmp_phase_q <= cmp_phase_d;
            rem_q       <= rem_d;
            big_m_q     <= big_m_d;
            small_m_q   <= small_m_d;
            cexp_q      <= cexp_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            special_q   <= special_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign out_big_m   = big_m_q;
    assign out_small_m = small_m_q;
    assign out_cexp    = cexp_q;
    assign out_sign    = sign_q;
    assign out_eff_sub = eff_sub_q;
    assign out_special = special_q;

endmodule

// File: tb/tb_fp32_align_shift.sv
// Randomized bench for fp32_align_shift against an arithmetic alignment model, with
// directed vectors, backpressure and mid-operation reset.
module tb_fp32_align_shift;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        in_op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [32:0] out_big_m;
    logic [32:0] out_small_m;
    logic [7:0]  out_cexp;
    logic        out_sign;
    logic        out_eff_sub;
    logic        out_special;

    fp32_align_shift dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_big_m   (out_big_m),
        .out_small_m (out_small_m),
        .out_cexp    (out_cexp),
        .out_sign    (out_sign),
        .out_eff_sub (out_eff_sub),
        .out_special (out_special)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int ready_mode = 0;  // 0 = high, 1 = random, 2 = low

    typedef struct {
        logic [32:0] big_m;
        logic [32:0] small_m;
        logic [7:0]  cexp;
        logic        sign;
        logic        eff_sub;
        logic        special;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    bit   seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Alignment computed directly: shift by the clamped difference, sticky = any bit lost
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
        exp_t r;
        int ea, eb, d;
        longint unsigned ma, mb, ms, sh;
        logic [63:0] tmp;
        bit a_big;
        ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
        ma = longint'({a[30:23] != 8'd0, a[22:0]}) << 8;
        mb = longint'({b[30:23] != 8'd0, b[22:0]}) << 8;
        a_big = (a[30:0] >= b[30:0]);
        d = a_big ? ea - eb : eb - ea;
        if (d > 33) d = 33;
        ms = a_big ? mb : ma;
        sh = ms >> d;
        if ((ms & ((64'd1 << d) - 64'd1)) != 0) sh = sh | 64'd1;
        tmp = sh;
        r.small_m = tmp[32:0];
        tmp = a_big ? ma : mb;
        r.big_m = tmp[32:0];
        r.cexp = a_big ? 8'(ea) : 8'(eb);
        r.sign = a_big ? a[31] : (b[31] ^ op);
        r.eff_sub = a[31] ^ b[31] ^ op;
        r.special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        r.lat = 2 + d / 4 + d % 4;
        r.acc = 0;
        return r;
    endfunction

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Compare process: every cycle out_valid is high the outputs must match the head entry
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious out_valid: got 1 want 0 (t=%0t)", $time);
            end else begin
                e = exp_q[0];
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                end
                chk("big_m", 64'(out_big_m), 64'(e.big_m));
                chk("small_m", 64'(out_small_m), 64'(e.small_m));
                chk("cexp", 64'(out_cexp), 64'(e.cexp));
                chk("sign", 64'(out_sign), 64'(e.sign));
                chk("eff_sub", 64'(out_eff_sub), 64'(e.eff_sub));
                chk("special", 64'(out_special), 64'(e.special));
                chk("in_ready_in_done", 64'(in_ready), 64'd0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accept edge
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic op);
        exp_t e;
        int w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk);
            #2;
            w++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready timeout: got 0 want 1");
            return;
        end
        e = model(a, b, op);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        in_a = a;
        in_b = b;
        in_op = op;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        // Inputs after the accept edge must not matter
        in_a = $urandom;
        in_b = $urandom;
        in_op = 1'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            #2;
            w++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain timeout: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic pin(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [32:0] big_m, input logic [32:0] small_m,
                       input logic [7:0] cexp, input logic sign, input logic eff_sub,
                       input int lat);
        exp_t m;
        m = model(a, b, op);
        chk({name, "_model_big_m"}, 64'(m.big_m), 64'(big_m));
        chk({name, "_model_small_m"}, 64'(m.small_m), 64'(small_m));
        chk({name, "_model_cexp"}, 64'(m.cexp), 64'(cexp));
        chk({name, "_model_sign"}, 64'(m.sign), 64'(sign));
        chk({name, "_model_eff_sub"}, 64'(m.eff_sub), 64'(eff_sub));
        chk({name, "_model_lat"}, 64'(m.lat), 64'(lat));
    endtask

    initial begin
        logic [31:0] ra, rb;
        int ea, eb;
        exp_t m;

        // Model pinned against hand-computed values
        pin("equal", 32'h3F800000, 32'h3F800000, 1'b0, 33'h080000000, 33'h080000000,
            8'h7F, 1'b0, 1'b0, 2);
        pin("swap", 32'h3F000000, 32'h3F800000, 1'b1, 33'h080000000, 33'h040000000,
            8'h7F, 1'b1, 1'b1, 3);
        pin("d24", 32'h3F800000, 32'h33800000, 1'b0, 33'h080000000, 33'h000000080,
            8'h7F, 1'b0, 1'b0, 8);
        pin("clamp", 32'h7F000000, 32'h3F800001, 1'b0, 33'h080000000, 33'h000000001,
            8'hFE, 1'b0, 1'b0, 11);
        pin("d1", 32'h3F800000, 32'h3F7FFFFF, 1'b0, 33'h080000000, 33'h07FFFFF80,
            8'h7F, 1'b0, 1'b0, 3);
        // Ones land in bits 22:0; the single dropped bit is also a one
        pin("d9", 32'h3F800000, 32'h3B7FFFFF, 1'b0, 33'h080000000, 33'h0007FFFFF,
            8'h7F, 1'b0, 1'b0, 5);
        m = model(32'h3F800000, 32'h00000000, 1'b0);
        chk("zero_model_small_m", 64'(m.small_m), 64'd0);
        m = model(32'h7F800000, 32'h3F800000, 1'b0);
        chk("special_model_flag", 64'(m.special), 64'd1);

        // Reset state
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_big_m", 64'(out_big_m), 64'd0);
        chk("rst_small_m", 64'(out_small_m), 64'd0);
        chk("rst_cexp", 64'(out_cexp), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Directed vectors
        do_op(32'h3F800000, 32'h3F800000, 1'b0);
        do_op(32'h3F000000, 32'h3F800000, 1'b1);
        do_op(32'h3F800000, 32'h33800000, 1'b0);
        do_op(32'h7F000000, 32'h3F800001, 1'b0);
        do_op(32'h3F800000, 32'h3F7FFFFF, 1'b0);
        do_op(32'h3F800000, 32'h3B7FFFFF, 1'b0);
        do_op(32'h3F800000, 32'h00000000, 1'b1);
        do_op(32'h7F800000, 32'h3F800000, 1'b0);
        do_op(32'h80000000, 32'h00000000, 1'b1);
        do_op(32'h00400000, 32'h00000001, 1'b0);
        drain();

        // Backpressure: hold out_ready low for five cycles in DONE
        ready_mode = 2;
        @(posedge clk);
        #2;
        do_op(32'hC0400000, 32'h3F800000, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (5) @(posedge clk);
        #2;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_still_valid", 64'(out_valid), 64'd1);
        ready_mode = 0;
        drain();

        // Reset during SHIFT of a d = 20 operation
        do_op(32'h3F800000, 32'h35800000, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_small_m", 64'(out_small_m), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        do_op(32'h3F800000, 32'h35800000, 1'b0);
        drain();

        // Randomized operands with exponent differences spread across the shift range
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            ea = $urandom_range(0, 255);
            eb = ea + $urandom_range(0, 80) - 40;
            if (eb < 0) eb = 0;
            if (eb > 255) eb = 255;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                ra[30:23] = 8'(ea);
                rb[30:23] = 8'(eb);
            end
            if ($urandom_range(0, 15) == 0) rb[30:0] = 31'd0;
            if ($urandom_range(0, 15) == 0) ra[22:0] = 23'd0;
            if ($urandom_range(0, 15) == 0) rb = ra;
            do_op(ra, rb, 1'($urandom));
        end
        ready_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
